// File: rtl/l3_port_arbiter.sv
// ----------------------------------------------------------------------------
// l3_port_arbiter
//
// Shares the single upstream slave port of the L3 cache between NUM_REQ L2
// requesters. Requests are arbitrated round-robin. One request at a time is
// captured into holding registers and replayed on the master port. Only one
// transaction is outstanding at any time, because the L3 FSM is not
// pipelined.
//
// Ports (requester buses are flattened; requester i uses slice [i*W +: W]):
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   s_ar*            per-requester read address channel (valid in, ready out)
//   s_r*             read data; s_rdata is shared, s_rvalid is one-hot
//   s_aw*, s_w*      per-requester write address + data, accepted together
//   s_b*             write response; s_bvalid is one-hot
//   m_*              master port toward the L3 upstream slave
//   grant_id         index of the requester owning the current transaction
//   busy             high whenever a transaction is in flight
// ----------------------------------------------------------------------------
module l3_port_arbiter #(
    parameter  int NUM_REQ    = 2,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    // requester side
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_awaddr,
    input  logic [NUM_REQ-1:0]            s_awvalid,
    output logic [NUM_REQ-1:0]            s_awready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_REQ-1:0]            s_wvalid,
    output logic [NUM_REQ-1:0]            s_wready,
    output logic [NUM_REQ-1:0]            s_bvalid,
    input  logic [NUM_REQ-1:0]            s_bready,
    // master side toward the L3
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic [ADDR_WIDTH-1:0]         m_awaddr,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    // status
    output logic [IDW-1:0]                grant_id,
    output logic                          busy
);

    // Candidate index width: rr_ptr + offset reaches 2*NUM_REQ-2 before wrap.
    localparam int CW = IDW + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]          grant_id_q, grant_id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic [NUM_REQ-1:0]      elig;
    logic [CW-1:0]           cand;
    logic                    win_found;
    logic [IDW-1:0]          win_idx;
    logic                    win_is_rd;
    logic [IDW-1:0]          next_ptr;

    // A write needs both AW and W present; half a write is never eligible.
    assign elig = s_arvalid | (s_awvalid & s_wvalid);

    // Round-robin search starting at rr_ptr, wrapping explicitly so that
    // non-power-of-two NUM_REQ never selects an index past NUM_REQ-1.
    // NOTE: every variable of a combinational block gets a default before any
    // branch, otherwise a path that skips the assignment infers a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_is_rd = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!win_found && elig[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
                // Within one requester a read beats a write.
                win_is_rd = s_arvalid[cand[IDW-1:0]];
            end
        end
    end

    assign next_ptr = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        s_arready  = '0;
        s_awready  = '0;
        s_rvalid   = '0;
        s_bvalid   = '0;
        s_rdata    = '0;
        m_arvalid  = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_rready   = 1'b0;
        m_bready   = 1'b0;

        case (state_q)
            IDLE: begin
                // NOTE: the accept readys are combinational from the valids,
                // so they are also gated by rst; otherwise a requester could
                // see a handshake while the arbiter is held in reset.
                if (win_found && !rst) begin
                    grant_id_d = win_idx;
                    if (win_is_rd) begin
                        s_arready[win_idx] = 1'b1;
                        addr_d  = s_araddr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        state_d = RD_ADDR;
                    end else begin
                        s_awready[win_idx] = 1'b1;
                        addr_d  = s_awaddr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_d = s_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        state_d = WR_ADDR;
                    end
                end
            end

            RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                m_rready             = s_rready[grant_id_q];
                s_rvalid[grant_id_q] = m_rvalid;
                s_rdata              = m_rdata;
                if (m_rvalid && s_rready[grant_id_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end

            WR_ADDR: begin
                m_awvalid = 1'b1;
                m_wvalid  = 1'b1;
                // The L3 must take address and data in the same cycle.
                if (m_awready && m_wready) begin
                    state_d = WR_RESP;
                end
            end

            WR_RESP: begin
                m_bready             = s_bready[grant_id_q];
                s_bvalid[grant_id_q] = m_bvalid;
                if (m_bvalid && s_bready[grant_id_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, as real hardware does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Holding registers feed the master port directly; they only load in
    // IDLE, so the master payload is stable until its handshake.
    assign s_wready = s_awready;
    assign m_araddr = addr_q;
    assign m_awaddr = addr_q;
    assign m_wdata  = wdata_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q != IDLE);

endmodule
